// File: rtl/vc_sec_pipe_reg.sv
// Elastic pipeline register with val/rdy handshake on both sides.
// Every stage carries a 1-bit security-domain tag next to its payload.
// A scrub request invalidates and zeroes every stage tagged secure.
// Empty stages always hold zero, so stale data can never leak out.

module vc_sec_pipe_reg #(
   parameter int  p_nbits   = 32,
   parameter int  p_nstages = 2,
   localparam int p_cntbits = $clog2(p_nstages + 1)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_val,
   output logic                 in_rdy,
   input  logic [p_nbits-1:0]   in_msg,
   input  logic                 in_domain,
   output logic                 out_val,
   input  logic                 out_rdy,
   output logic [p_nbits-1:0]   out_msg,
   output logic                 out_domain,
   input  logic                 scrub,
   output logic [p_cntbits-1:0] count
);

   localparam int last = p_nstages - 1;

   logic [p_nstages-1:0] v;
   logic [p_nstages-1:0] d;
   logic [p_nbits-1:0]   m [p_nstages];

   logic [p_nstages-1:0] v_next;
   logic [p_nstages-1:0] d_next;
   logic [p_nbits-1:0]   m_next [p_nstages];
   logic [p_cntbits-1:0] count_next;

   logic [p_nstages-1:0] go;
   logic                 load;

   // Ready ripples back from the consumer: a stage moves on if the next one is empty or moving too
   always_comb begin
      go       = '0;
      go[last] = v[last] & out_rdy;
      for (int i = last - 1; i >= 0; i--) begin
         go[i] = v[i] & (~v[i+1] | go[i+1]);
      end
      in_rdy = ~v[0] | go[0];
   end

   // Next state: shift/load/clear each stage, then purge secure entries on scrub, then recount
   always_comb begin
      load   = in_val & in_rdy;
      v_next = v;
      d_next = d;
      for (int i = 0; i < p_nstages; i++) begin
         m_next[i] = m[i];
      end

      if (load) begin
         v_next[0] = 1'b1;
         m_next[0] = in_msg;
         d_next[0] = in_domain;
      end else if (go[0]) begin
         v_next[0] = 1'b0;
         m_next[0] = '0;
         d_next[0] = 1'b0;
      end

      for (int i = 1; i < p_nstages; i++) begin
         if (go[i-1]) begin
            v_next[i] = 1'b1;
            m_next[i] = m[i-1];
            d_next[i] = d[i-1];
         end else if (go[i]) begin
            v_next[i] = 1'b0;
            m_next[i] = '0;
            d_next[i] = 1'b0;
         end
      end

      for (int i = 0; i < p_nstages; i++) begin
         if (scrub && d_next[i]) begin
            v_next[i] = 1'b0;
            m_next[i] = '0;
            d_next[i] = 1'b0;
         end
      end

      count_next = '0;
      for (int i = 0; i < p_nstages; i++) begin
         count_next = count_next + p_cntbits'(v_next[i]);
      end
   end

   // Stage registers and occupancy count; async reset empties and zeroes the pipe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v     <= '0;
         d     <= '0;
         count <= '0;
         for (int i = 0; i < p_nstages; i++) begin
            m[i] <= '0;
         end
      end else begin
         v     <= v_next;
         d     <= d_next;
         count <= count_next;
         for (int i = 0; i < p_nstages; i++) begin
            m[i] <= m_next[i];
         end
      end
   end

   assign out_val    = v[last];
   assign out_msg    = m[last];
   assign out_domain = d[last];

endmodule
